dp_sync_ram: RTL

DP_SYNC_RAM -- requirements
Module: dp_sync_ram

---
 rtl/dp_sync_ram_if.sv | 33 +++
 rtl/dp_sync_ram.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dp_sync_ram_if.sv
// Command/response bundle for dp_sync_ram: clear control, port A (read/write), port B (read-only).
// Latency: pure wiring, no storage.
// Backpressure: none; commands are dropped by the RAM while busy is high.
//   master: drives clr_req, a_en/a_we/a_addr/a_din, b_en/b_addr; observes busy, a/b dout+valid
//   slave : the RAM side of the same signals
interface dp_sync_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_LANES  = 1
);
  logic                  clr_req;
  logic                  busy;
  logic                  a_en;
  logic [NUM_LANES-1:0]  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_dout;
  logic                  a_valid;
  logic                  b_en;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;

  modport master (
    output clr_req, a_en, a_we, a_addr, a_din, b_en, b_addr,
    input  busy, a_dout, a_valid, b_dout, b_valid
  );

  modport slave (
    input  clr_req, a_en, a_we, a_addr, a_din, b_en, b_addr,
    output busy, a_dout, a_valid, b_dout, b_valid
  );
endinterface

// File: rtl/dp_sync_ram.sv
// Dual-port synchronous RAM: port A read/write with lane enables, port B read-only, hardware clear sweep.
// Latency: read data + valid 1 cycle after an accepted strobe (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; while busy (clear sweep) strobes are silently dropped, in-flight reads still drain.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset; starts a full clear sweep on release
//   bus : dp_sync_ram_if slave (clr_req/busy, port A a_*, port B b_*)
module dp_sync_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_LANES  = 1,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic         clk,
  input logic         rst,
  dp_sync_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / NUM_LANES;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  a_acc, a_wr, b_acc, b_hit;
  logic [DATA_WIDTH-1:0] a_old, b_old, merged, a_rd, b_rd;

  // Commands only count in IDLE; the sweep owns the array while clearing.
  assign a_acc = (state == IDLE) && bus.a_en;
  assign a_wr  = a_acc && (|bus.a_we);
  assign b_acc = (state == IDLE) && bus.b_en;
  assign b_hit = a_wr && (bus.a_addr == bus.b_addr);

  assign a_old = mem[bus.a_addr];
  assign b_old = mem[bus.b_addr];

  // Post-write view of word[a_addr]: written lanes from a_din, the rest old data.
  always_comb begin
    merged = a_old;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (bus.a_we[i]) merged[i*LW +: LW] = bus.a_din[i*LW +: LW];
    end
  end

  // Write-first mode forwards the merged word to any same-address read this cycle.
  assign a_rd = (RDW_MODE != 0 && a_wr)  ? merged : a_old;
  assign b_rd = (RDW_MODE != 0 && b_hit) ? merged : b_old;

  // Clear FSM: CLEAR sweeps cnt 0..DEPTH-1, leaving on the edge that writes the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_WIDTH{1'b1}}) state <= IDLE;
        end
        IDLE: begin
          if (bus.clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy = (state == CLEAR);

  // Array has no reset; its contents become defined once a sweep completes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (a_wr) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (bus.a_we[i]) mem[bus.a_addr][i*LW +: LW] <= bus.a_din[i*LW +: LW];
      end
    end
  end

  // First read stage: data regs only load on an accepted strobe so outputs hold otherwise.
  logic                  a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d1, b_d1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_acc;
      b_v1 <= b_acc;
      if (a_acc) a_d1 <= a_rd;
      if (b_acc) b_d1 <= b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Second stage is not gated by busy so a read launched before a clear still completes.
      logic                  a_v2, b_v2;
      logic [DATA_WIDTH-1:0] a_d2, b_d2;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          a_v2 <= 1'b0;
          b_v2 <= 1'b0;
          a_d2 <= '0;
          b_d2 <= '0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end

      assign bus.a_valid = a_v2;
      assign bus.a_dout  = a_d2;
      assign bus.b_valid = b_v2;
      assign bus.b_dout  = b_d2;
    end else begin : g_no_out_reg
      assign bus.a_valid = a_v1;
      assign bus.a_dout  = a_d1;
      assign bus.b_valid = b_v1;
      assign bus.b_dout  = b_d1;
    end
  endgenerate
endmodule
